// File: rtl/microwave_timer_ctrl.sv
// Microwave MM:SS cook-timer sequencer: keypad entry, start/pause/clear,
// door interlock and a 4-digit BCD countdown driven by a 1 Hz strobe.
module microwave_timer_ctrl #(
  parameter int unsigned QUICK_T = 3,
  parameter int unsigned QUICK_U = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_open,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [2:0] state,
  output logic       mag_on,
  output logic       done
);

  localparam int unsigned DW = 4;
  localparam int unsigned SW = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [SW-1:0] state_q, state_d;
  logic [DW-1:0] min_t_q, min_t_d, min_u_q, min_u_d;
  logic [DW-1:0] sec_t_q, sec_t_d, sec_u_q, sec_u_d;
  logic          done_q, done_d;

  logic [DW-1:0] dec_min_t, dec_min_u, dec_sec_t, dec_sec_u;
  logic          borrow_su, borrow_st, borrow_mu;
  logic          time_zero, dec_zero, key_ok;

  // One-second decrement with mod-10 / mod-6 borrow chain; sec_t above 5 just counts down.
  always_comb begin
    borrow_su = (sec_u_q == 4'd0);
    borrow_st = borrow_su && (sec_t_q == 4'd0);
    borrow_mu = borrow_st && (min_u_q == 4'd0);
    dec_sec_u = borrow_su ? 4'd9 : sec_u_q - 4'd1;
    dec_sec_t = borrow_su ? ((sec_t_q == 4'd0) ? 4'd5 : sec_t_q - 4'd1) : sec_t_q;
    dec_min_u = borrow_st ? ((min_u_q == 4'd0) ? 4'd9 : min_u_q - 4'd1) : min_u_q;
    dec_min_t = borrow_mu ? min_t_q - 4'd1 : min_t_q;
  end

  assign time_zero = ({min_t_q, min_u_q, sec_t_q, sec_u_q} == 16'd0);
  assign dec_zero  = ({dec_min_t, dec_min_u, dec_sec_t, dec_sec_u} == 16'd0);
  assign key_ok    = key_valid && (key_digit <= 4'd9);

  always_comb begin
    state_d = state_q;
    min_t_d = min_t_q;
    min_u_d = min_u_q;
    sec_t_d = sec_t_q;
    sec_u_d = sec_u_q;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (door_open) begin
          state_d = state_q;
        end else if (stop_clear) begin
          state_d = S_IDLE;
          {min_t_d, min_u_d, sec_t_d, sec_u_d} = 16'd0;
        end else if (start) begin
          if (state_q == S_IDLE) begin
            state_d = S_COOK;
            {min_t_d, min_u_d} = 8'd0;
            sec_t_d = DW'(QUICK_T);
            sec_u_d = DW'(QUICK_U);
          end else begin
            state_d = time_zero ? S_IDLE : S_COOK;
          end
        end else if (key_ok) begin
          state_d = S_ENTRY;
          min_t_d = min_u_q;
          min_u_d = sec_t_q;
          sec_t_d = sec_u_q;
          sec_u_d = key_digit;
        end
      end
      S_COOK: begin
        if (door_open || stop_clear) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          min_t_d = dec_min_t;
          min_u_d = dec_min_u;
          sec_t_d = dec_sec_t;
          sec_u_d = dec_sec_u;
          if (dec_zero) state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (door_open) begin
          state_d = S_PAUSE;
        end else if (stop_clear) begin
          state_d = S_IDLE;
          {min_t_d, min_u_d, sec_t_d, sec_u_d} = 16'd0;
        end else if (start) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (door_open || stop_clear) begin
          state_d = S_IDLE;
          {min_t_d, min_u_d, sec_t_d, sec_u_d} = 16'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        {min_t_d, min_u_d, sec_t_d, sec_u_d} = 16'd0;
      end
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      min_t_q <= '0;
      min_u_q <= '0;
      sec_t_q <= '0;
      sec_u_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_t_q <= min_t_d;
      min_u_q <= min_u_d;
      sec_t_q <= sec_t_d;
      sec_u_q <= sec_u_d;
      done_q  <= done_d;
    end
  end

  // Magnetron must drop in the same cycle the door opens, so this one is combinational.
  assign mag_on = (state_q == S_COOK) && !door_open;
  assign done   = done_q;
  assign state  = state_q;
  assign min_t  = min_t_q;
  assign min_u  = min_u_q;
  assign sec_t  = sec_t_q;
  assign sec_u  = sec_u_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed self-checking bench for microwave_timer_ctrl.
module tb_microwave_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, key_valid, start, stop_clear, door_open;
  logic [3:0] key_digit;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic [2:0] state;
  logic       mag_on, done;

  int n_assert = 0;
  int n_fail   = 0;

  microwave_timer_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .start      (start),
    .stop_clear (stop_clear),
    .door_open  (door_open),
    .min_t      (min_t),
    .min_u      (min_u),
    .sec_t      (sec_t),
    .sec_u      (sec_u),
    .state      (state),
    .mag_on     (mag_on),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] t, input logic [2:0] st,
                         input logic mg, input logic dn);
    chk({tag, ".time"},   {16'd0, min_t, min_u, sec_t, sec_u}, {16'd0, t});
    chk({tag, ".state"},  {29'd0, state}, {29'd0, st});
    chk({tag, ".mag_on"}, {31'd0, mag_on}, {31'd0, mg});
    chk({tag, ".done"},   {31'd0, done}, {31'd0, dn});
  endtask

  // Hold the given strobes for one clock edge, then sample 1 time unit later.
  task automatic step(input logic t, input logic kv, input logic [3:0] kd,
                      input logic s, input logic sc);
    tick = t; key_valid = kv; key_digit = kd; start = s; stop_clear = sc;
    @(posedge clk);
    #1;
    tick = 1'b0; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop_clear = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);   step(1'b0, 1'b1, d, 1'b0, 1'b0); endtask
  task automatic do_start();                 step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0); endtask
  task automatic do_clear();                 step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1); endtask
  task automatic do_tick();                  step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0); endtask

  initial begin
    reset = 1'b1; tick = 0; key_valid = 0; key_digit = 0; start = 0; stop_clear = 0; door_open = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_init", 16'h0000, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Reset mid-cook at 01:23 takes effect before any clock edge
    key(4'd1); key(4'd2); key(4'd3);
    chk_all("entry_0123", 16'h0123, 3'd1, 1'b0, 1'b0);
    do_start();
    chk_all("cook_0123", 16'h0123, 3'd2, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 13:05 countdown through a minute borrow
    key(4'd1); key(4'd3); key(4'd0); key(4'd5);
    do_start();
    chk_all("cook_1305", 16'h1305, 3'd2, 1'b1, 1'b0);
    do_tick();
    chk_all("tick_1304", 16'h1304, 3'd2, 1'b1, 1'b0);
    repeat (4) do_tick();
    chk_all("tick_1300", 16'h1300, 3'd2, 1'b1, 1'b0);
    do_tick();
    chk_all("tick_1259", 16'h1259, 3'd2, 1'b1, 1'b0);
    do_clear();
    chk_all("cook_pause", 16'h1259, 3'd3, 1'b0, 1'b0);
    do_clear();
    chk_all("pause_clear", 16'h0000, 3'd0, 1'b0, 1'b0);

    // 0:90 entry counts 90 seconds to DONE
    key(4'd9); key(4'd0); do_start();
    chk_all("cook_0090", 16'h0090, 3'd2, 1'b1, 1'b0);
    repeat (30) do_tick();
    chk_all("tick_0060", 16'h0060, 3'd2, 1'b1, 1'b0);
    do_tick();
    chk_all("tick_0059", 16'h0059, 3'd2, 1'b1, 1'b0);
    repeat (58) do_tick();
    chk_all("tick_0001", 16'h0001, 3'd2, 1'b1, 1'b0);
    do_tick();
    chk_all("done_0000", 16'h0000, 3'd4, 1'b0, 1'b1);
    do_tick(); key(4'd5); do_start();
    chk_all("done_ignores", 16'h0000, 3'd4, 1'b0, 1'b1);
    do_clear();
    chk_all("done_clear", 16'h0000, 3'd0, 1'b0, 1'b0);

    // Quick start, door interlock, resume
    do_start();
    chk_all("quick_0030", 16'h0030, 3'd2, 1'b1, 1'b0);
    repeat (13) do_tick();
    chk_all("tick_0017", 16'h0017, 3'd2, 1'b1, 1'b0);
    door_open = 1'b1;
    #1;
    chk("door_mag_same_cycle", {31'd0, mag_on}, 32'd0);
    chk("door_state_same_cycle", {29'd0, state}, 32'd2);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    chk_all("door_pause", 16'h0017, 3'd3, 1'b0, 1'b0);
    do_tick(); do_tick();
    chk_all("pause_hold", 16'h0017, 3'd3, 1'b0, 1'b0);
    do_start();
    chk_all("pause_door_start", 16'h0017, 3'd3, 1'b0, 1'b0);
    door_open = 1'b0;
    do_tick();
    chk_all("pause_tick_ign", 16'h0017, 3'd3, 1'b0, 1'b0);
    do_start();
    chk_all("resume", 16'h0017, 3'd2, 1'b1, 1'b0);
    do_tick();
    chk_all("resume_0016", 16'h0016, 3'd2, 1'b1, 1'b0);

    // tick + stop_clear together in COOK -> pause without decrement
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    chk_all("tick_stop", 16'h0016, 3'd3, 1'b0, 1'b0);
    do_clear();
    chk_all("back_idle", 16'h0000, 3'd0, 1'b0, 1'b0);

    // IDLE start with door open does nothing
    door_open = 1'b1;
    do_start();
    chk_all("idle_door_start", 16'h0000, 3'd0, 1'b0, 1'b0);
    door_open = 1'b0;

    // Invalid digit ignored, zero entry + start -> IDLE
    key(4'd12);
    chk_all("key_12", 16'h0000, 3'd0, 1'b0, 1'b0);
    key(4'd0);
    chk_all("entry_zero", 16'h0000, 3'd1, 1'b0, 1'b0);
    do_start();
    chk_all("zero_start", 16'h0000, 3'd0, 1'b0, 1'b0);

    // Borrow across all digits
    key(4'd1); key(4'd0); key(4'd0); key(4'd0); do_start();
    chk_all("cook_1000", 16'h1000, 3'd2, 1'b1, 1'b0);
    do_tick();
    chk_all("tick_0959", 16'h0959, 3'd2, 1'b1, 1'b0);
    do_clear(); do_clear();
    key(4'd9); key(4'd9); key(4'd9); key(4'd9); key(4'd7);
    chk_all("entry_shiftout", 16'h9997, 3'd1, 1'b0, 1'b0);
    do_clear();
    chk_all("entry_clear", 16'h0000, 3'd0, 1'b0, 1'b0);
    key(4'd9); key(4'd9); key(4'd9); key(4'd9); do_start();
    do_tick();
    chk_all("tick_9998", 16'h9998, 3'd2, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
